// File: rtl/traffic_light_monitor_pkg.sv
// Shared lamp encodings, phase indices and error codes for the traffic-light controller,
// its monitor and the benches.
package traffic_light_monitor_pkg;

    // {red, amber, green}
    localparam logic [2:0] LampsRed       = 3'b100;
    localparam logic [2:0] LampsRedAmber  = 3'b110;
    localparam logic [2:0] LampsGreen     = 3'b001;
    localparam logic [2:0] LampsAmber     = 3'b010;

    typedef enum logic [1:0] {
        PhRed      = 2'd0,
        PhRedAmber = 2'd1,
        PhGreen    = 2'd2,
        PhAmber    = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        ErrNone    = 3'd0,
        ErrIllegal = 3'd1,
        ErrSkip    = 3'd2,
        ErrShort   = 3'd3,
        ErrTimeout = 3'd4
    } err_code_e;

    function automatic phase_e phase_succ(input phase_e ph);
        phase_e nxt;
        unique case (ph)
            PhRed:      nxt = PhRedAmber;
            PhRedAmber: nxt = PhGreen;
            PhGreen:    nxt = PhAmber;
            PhAmber:    nxt = PhRed;
            default:    nxt = PhRed;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp bundle between a traffic-light controller (master) and its observers (slave).
interface traffic_light_monitor_if;

    logic red;
    logic amber;
    logic green;

    modport master (output red, output amber, output green);
    modport slave  (input red, input amber, input green);

endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker of the UK light sequence and per-phase hold times; reports the first
// error since the last clear and counts completed light cycles.
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int unsigned MIN_HOLD = 1,
    parameter int unsigned MAX_HOLD = 1,
    parameter int unsigned HOLD_W   = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    traffic_light_monitor_if.slave        lamps,
    input  logic                          err_clr_i,
    output logic                          locked_o,
    output logic [1:0]                    phase_o,
    output logic                          err_o,
    output logic [2:0]                    err_code_o,
    output logic [CNT_W-1:0]              cycle_cnt_o
);

    localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HoldMin = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

    logic              locked_q;
    phase_e            phase_q;
    logic [HOLD_W-1:0] hold_q;
    logic              err_q;
    err_code_e         err_code_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [2:0] pat;
    logic       pat_legal;
    phase_e     pat_phase;
    phase_e     next_phase;
    err_code_e  ev;

    assign pat        = {lamps.red, lamps.amber, lamps.green};
    assign next_phase = phase_succ(phase_q);

    always_comb begin
        pat_legal = 1'b1;
        pat_phase = PhRed;
        case (pat)
            LampsRed:      pat_phase = PhRed;
            LampsRedAmber: pat_phase = PhRedAmber;
            LampsGreen:    pat_phase = PhGreen;
            LampsAmber:    pat_phase = PhAmber;
            default:       pat_legal = 1'b0;
        endcase
    end

    // Classify this sample; only meaningful while locked, ordered by priority.
    always_comb begin
        ev = ErrNone;
        if (locked_q) begin
            if (!pat_legal) begin
                ev = ErrIllegal;
            end else if (pat_phase == phase_q) begin
                if (hold_q == HoldMax) ev = ErrTimeout;
            end else if (pat_phase == next_phase) begin
                if (hold_q < HoldMin) ev = ErrShort;
            end else begin
                ev = ErrSkip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q   <= 1'b0;
            phase_q    <= PhRed;
            hold_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            cnt_q      <= '0;
        end else begin
            if (!locked_q) begin
                if (pat_legal) begin
                    locked_q <= 1'b1;
                    phase_q  <= pat_phase;
                    hold_q   <= HoldOne;
                end
            end else if (ev != ErrNone) begin
                locked_q <= 1'b0;
                hold_q   <= '0;
            end else if (pat_phase == phase_q) begin
                hold_q <= hold_q + HoldOne;
            end else begin
                phase_q <= pat_phase;
                hold_q  <= HoldOne;
                if (phase_q == PhAmber) cnt_q <= cnt_q + CntOne;
            end

            // A clear in the same cycle as a new error lets the new code through.
            if (ev != ErrNone) begin
                err_q <= 1'b1;
                if (!err_q || err_clr_i) err_code_q <= ev;
            end else if (err_clr_i) begin
                err_q      <= 1'b0;
                err_code_q <= ErrNone;
            end
        end
    end

    assign locked_o    = locked_q;
    assign phase_o     = phase_q;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;
    assign cycle_cnt_o = cnt_q;

endmodule
